// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches 32-bit words over req/ack, presents them to the decoder.
// Latency: one BOOT cycle after reset, then >=1 cycle per fetch (FETCH) and >=1 cycle per execute (HOLD).
// Backpressure: waits in FETCH until imem_ack and in HOLD until instr_accept; neither wait is bounded.
module instr_fetch_unit #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic              CLK,
   input  logic              resetl,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [10:0]       opcode,
   output logic [PC_W-1:0]   pc_out,
   output logic              instr_valid,
   input  logic              instr_accept,
   input  logic              branch,
   input  logic              uncond_branch,
   input  logic              zero,
   input  logic [PC_W-1:0]   br_offset,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic              take;
   logic [PC_W-1:0]   pc_seq;
   logic [PC_W-1:0]   pc_br;
   logic [PC_W-1:0]   pc_next;

   // Next-PC candidates: sequential and branch target, both modulo 2^PC_W.
   // The word offset is shifted left by two, dropping its top two bits.
   always_comb begin
      pc_seq = pc_q + PC_W'(4);
      pc_br  = pc_q + {br_offset[PC_W-3:0], 2'b00};
      // Unconditional branch dominates so an undefined CBZ control cannot
      // disturb the PC when B is asserted.
      take    = uncond_branch ? 1'b1 : (branch & zero);
      pc_next = take ? pc_br : pc_seq;
   end

   // Next-state logic: BOOT -> FETCH -> HOLD -> FETCH ...; stray ack/accept
   // outside their own state fall through to the hold-everything default.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (instr_accept) begin
               pc_d      = pc_next;
               retired_d = retired_q + CNT_W'(1);
               state_d   = FETCH;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State register; reset abandons any outstanding fetch.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   // Outputs are decoded from state or driven straight from registers.
   always_comb begin
      imem_req    = (state_q == FETCH);
      instr_valid = (state_q == HOLD);
      imem_addr   = pc_q;
      pc_out      = pc_q;
      instr       = instr_q;
      opcode      = instr_q[31:21];
      retired     = retired_q;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   // main instance, RESET_PC = 0
   logic        resetl;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [10:0] opcode;
   logic [63:0] pc_out;
   logic        instr_valid;
   logic        instr_accept;
   logic        branch;
   logic        uncond_branch;
   logic        zero;
   logic [63:0] br_offset;
   logic [31:0] retired;

   // wrap instance, PC starts at the top word, 2-bit retire counter
   logic        resetl2;
   logic        req2;
   logic [63:0] addr2;
   logic        ack2;
   logic [31:0] rdata2;
   logic [31:0] instr2;
   logic [10:0] opcode2;
   logic [63:0] pc2;
   logic        valid2;
   logic        accept2;
   logic        branch2;
   logic        ub2;
   logic        zero2;
   logic [63:0] off2;
   logic [1:0]  retired2;

   int          vectors    = 0;
   int          miscompares = 0;

   exp_t        sb[$];
   logic [63:0] model_pc;
   logic [31:0] model_ret;

   instr_fetch_unit #(.PC_W(64), .RESET_PC(64'h0), .CNT_W(32)) u_dut (
      .CLK(CLK), .resetl(resetl),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .pc_out(pc_out),
      .instr_valid(instr_valid), .instr_accept(instr_accept),
      .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
      .br_offset(br_offset), .retired(retired)
   );

   instr_fetch_unit #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(2)) u_top (
      .CLK(CLK), .resetl(resetl2),
      .imem_req(req2), .imem_addr(addr2),
      .imem_ack(ack2), .imem_rdata(rdata2),
      .instr(instr2), .opcode(opcode2), .pc_out(pc2),
      .instr_valid(valid2), .instr_accept(accept2),
      .branch(branch2), .uncond_branch(ub2), .zero(zero2),
      .br_offset(off2), .retired(retired2)
   );

   // Fetch one word: optional ack delay, then push expectation and compare in HOLD.
   task automatic do_fetch(input logic [31:0] rdata, input int delay);
      int   guard;
      exp_t e;
      guard = 0;
      while (imem_req !== 1'b1 && guard < 10) begin
         @(negedge CLK);
         guard++;
      end
      vectors++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_start: req=%b valid=%b, want req=1 valid=0", imem_req, instr_valid);
      end
      for (int i = 0; i < delay; i++) begin
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_stall%0d: req=%b addr=%h valid=%b, want req=1 addr=%h valid=0",
                     i, imem_req, imem_addr, instr_valid, model_pc);
         end
         @(negedge CLK);
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      sb.push_back('{pc: model_pc, word: rdata});
      @(negedge CLK);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      vectors++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_entry: valid=%b req=%b, want valid=1 req=0", instr_valid, imem_req);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if (instr !== e.word || opcode !== e.word[31:21] || pc_out !== e.pc) begin
            miscompares++;
            $display("FAIL held_instr: instr=%h opcode=%h pc=%h, want instr=%h opcode=%h pc=%h",
                     instr, opcode, pc_out, e.word, e.word[31:21], e.pc);
         end
      end
   endtask

   // Accept the held instruction with the given branch controls and check the next fetch.
   task automatic do_accept(input logic br, input logic ub, input logic z, input logic [63:0] off);
      logic tk;
      branch        = br;
      uncond_branch = ub;
      zero          = z;
      br_offset     = off;
      instr_accept  = 1'b1;
      tk = ub ? 1'b1 : (br & z);
      model_pc  = tk ? model_pc + {off[61:0], 2'b00} : model_pc + 64'd4;
      model_ret = model_ret + 32'd1;
      @(negedge CLK);
      instr_accept  = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b0;
      zero          = 1'b0;
      br_offset     = 64'($urandom);
      vectors++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== model_pc || retired !== model_ret) begin
         miscompares++;
         $display("FAIL accept: valid=%b req=%b addr=%h retired=%0d, want valid=0 req=1 addr=%h retired=%0d",
                  instr_valid, imem_req, imem_addr, retired, model_pc, model_ret);
      end
   endtask

   task automatic test_reset;
      resetl = 1'b0;
      #1;
      vectors++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || opcode !== 11'h0 ||
          pc_out !== 64'h0 || imem_addr !== 64'h0 || retired !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_values: req=%b valid=%b instr=%h opcode=%h pc=%h retired=%0d, want all zero",
                  imem_req, instr_valid, instr, opcode, pc_out, retired);
      end
      @(negedge CLK);
      @(negedge CLK);
      resetl = 1'b1;
      #1;
      vectors++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL boot_cycle: req=%b valid=%b, want req=0 valid=0", imem_req, instr_valid);
      end
      @(negedge CLK);
      vectors++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 64'h0) begin
         miscompares++;
         $display("FAIL first_fetch: req=%b valid=%b addr=%h, want req=1 valid=0 addr=0",
                  imem_req, instr_valid, imem_addr);
      end
   endtask

   task automatic test_sequential;
      for (int i = 0; i < 4; i++) begin
         do_fetch(32'h8B02_0020, 0);
         vectors++;
         if (opcode !== 11'b10001011000 || pc_out !== 64'(4 * i)) begin
            miscompares++;
            $display("FAIL seq_opcode%0d: opcode=%b pc=%h, want opcode=10001011000 pc=%h",
                     i, opcode, pc_out, 64'(4 * i));
         end
         do_accept(1'b0, 1'b0, 1'b0, 64'h0);
      end
      vectors++;
      if (retired !== 32'd4) begin
         miscompares++;
         $display("FAIL seq_retired: retired=%0d, want 4", retired);
      end
   endtask

   task automatic test_fetch_stall;
      do_fetch($urandom, 5);
      // branch from 0x10 to 0x40
      do_accept(1'b0, 1'b1, 1'b0, 64'd12);
   endtask

   task automatic test_uncond_branch;
      do_fetch($urandom, 0);
      vectors++;
      if (pc_out !== 64'h40) begin
         miscompares++;
         $display("FAIL b_start_pc: pc=%h, want 0000000000000040", pc_out);
      end
      do_accept(1'bx, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
      vectors++;
      if (imem_addr !== 64'h30) begin
         miscompares++;
         $display("FAIL b_backward: addr=%h, want 0000000000000030", imem_addr);
      end
   endtask

   task automatic test_cbz;
      do_fetch($urandom, 0);
      do_accept(1'b0, 1'b1, 1'b0, 64'd52);
      do_fetch($urandom, 0);
      do_accept(1'b1, 1'b0, 1'b1, 64'd3);
      vectors++;
      if (imem_addr !== 64'h10C) begin
         miscompares++;
         $display("FAIL cbz_taken: addr=%h, want 000000000000010c", imem_addr);
      end
      do_fetch($urandom, 0);
      do_accept(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
      do_fetch($urandom, 0);
      do_accept(1'b1, 1'b0, 1'b0, 64'd3);
      vectors++;
      if (imem_addr !== 64'h104) begin
         miscompares++;
         $display("FAIL cbz_not_taken: addr=%h, want 0000000000000104", imem_addr);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge CLK);
      resetl = 1'b0;
      #1;
      vectors++;
      if (imem_req !== 1'b0 || pc_out !== 64'h0 || instr !== 32'h0 || retired !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_reset: req=%b pc=%h instr=%h retired=%0d, want req=0 pc=0 instr=0 retired=0",
                  imem_req, pc_out, instr, retired);
      end
      @(negedge CLK);
      resetl     = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge CLK);
      imem_ack   = 1'b0;
      vectors++;
      if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         miscompares++;
         $display("FAIL late_ack: instr=%h valid=%b req=%b addr=%h, want instr=0 valid=0 req=1 addr=0",
                  instr, instr_valid, imem_req, imem_addr);
      end
      model_pc  = 64'h0;
      model_ret = 32'h0;
      sb.delete();
      do_fetch(32'h8B02_0020, 0);
      do_accept(1'b0, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic test_wrap;
      logic [63:0] e_addr;
      @(negedge CLK);
      resetl2 = 1'b1;
      @(negedge CLK);
      vectors++;
      if (req2 !== 1'b1 || addr2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         miscompares++;
         $display("FAIL top_fetch: req=%b addr=%h, want req=1 addr=fffffffffffffffc", req2, addr2);
      end
      for (int k = 0; k < 4; k++) begin
         ack2   = 1'b1;
         rdata2 = 32'h1234_0000 + 32'(k);
         @(negedge CLK);
         ack2   = 1'b0;
         vectors++;
         if (valid2 !== 1'b1 || instr2 !== 32'h1234_0000 + 32'(k)) begin
            miscompares++;
            $display("FAIL top_hold%0d: valid=%b instr=%h, want valid=1 instr=%h",
                     k, valid2, instr2, 32'h1234_0000 + 32'(k));
         end
         if (k == 0) begin
            // stray acks and branch controls while holding must be ignored
            ack2 = 1'b1; rdata2 = 32'hFFFF_FFFF; ub2 = 1'b1; off2 = 64'd100;
            @(negedge CLK);
            @(negedge CLK);
            ack2 = 1'b0; ub2 = 1'b0; off2 = 64'h0;
            vectors++;
            if (valid2 !== 1'b1 || instr2 !== 32'h1234_0000 || pc2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
               miscompares++;
               $display("FAIL spurious_ack: valid=%b instr=%h pc=%h, want valid=1 instr=12340000 pc=fffffffffffffffc",
                        valid2, instr2, pc2);
            end
         end
         accept2 = 1'b1;
         @(negedge CLK);
         accept2 = 1'b0;
         e_addr = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * (k + 1));
         vectors++;
         if (req2 !== 1'b1 || addr2 !== e_addr || retired2 !== 2'(k + 1)) begin
            miscompares++;
            $display("FAIL top_accept%0d: req=%b addr=%h retired=%0d, want req=1 addr=%h retired=%0d",
                     k, req2, addr2, retired2, e_addr, 2'(k + 1));
         end
      end
      vectors++;
      if (retired2 !== 2'd0) begin
         miscompares++;
         $display("FAIL retired_wrap: retired=%0d, want 0", retired2);
      end
   endtask

   initial begin
      resetl = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_accept = 1'b0;
      branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0; br_offset = 64'h0;
      resetl2 = 1'b0; ack2 = 1'b0; rdata2 = 32'h0; accept2 = 1'b0;
      branch2 = 1'b0; ub2 = 1'b0; zero2 = 1'b0; off2 = 64'h0;
      model_pc = 64'h0; model_ret = 32'h0;
      @(negedge CLK);
      test_reset;
      test_sequential;
      test_fetch_stall;
      test_uncond_branch;
      test_cbz;
      test_reset_mid;
      test_wrap;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle control decoder.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents the instruction and its 11-bit opcode field (instr[31:21]) until the downstream stage accepts it.
- Computes the next PC from the branch/uncond_branch decisions and the zero flag that come back from control/ALU.

Parameters:
- PC_W, 64, width of PC, memory address and branch offset.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- resetl  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_W  fetch address; always equals pc_out.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  held instruction.
- opcode  output  11  instr[31:21]; feeds the control decoder.
- pc_out  output  PC_W  PC of the held/being-fetched instruction.
- instr_valid  output  1  instr/opcode/pc_out are valid for execution.
- instr_accept  input  1  downstream has finished executing instr.
- branch  input  1  conditional-branch control (CBZ).
- uncond_branch  input  1  unconditional-branch control (B).
- zero  input  1  ALU zero flag for the held instruction.
- br_offset  input  PC_W  sign-extended word offset from the sign extender.
- retired  output  CNT_W  count of accepted instructions.

Behaviour:
- Reset (resetl=0, asynchronous):
  - state=BOOT, pc=RESET_PC, instr=0, retired=0.
  - imem_req=0, instr_valid=0.
  - opcode=0, which decodes as the control default (no writes).
- States: BOOT, FETCH, HOLD. All outputs are registered or are a pure function of state/registers.
- BOOT:
  - imem_req=0, instr_valid=0.
  - Unconditionally moves to FETCH on the next edge; gives one clean cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc. Addr is held stable until ack.
  - On imem_ack=1: instr<=imem_rdata and state<=HOLD.
  - Without ack: remain in FETCH indefinitely; no timeout.
  - Minimum fetch latency is 1 cycle (ack in the first FETCH cycle).
- HOLD:
  - imem_req=0, instr_valid=1.
  - instr, opcode and pc_out are stable until accept.
  - Branch inputs are sampled only in the accept cycle.
  - On instr_accept=1:
    - take = uncond_branch | (branch & zero).
    - pc <= take ? pc + (br_offset << 2) : pc + 4.
    - retired <= retired + 1.
    - state <= FETCH.
  - On instr_accept=0: stay in HOLD.
- Arithmetic: all PC arithmetic is modulo 2^PC_W.
  - The shift drops the top 2 bits of br_offset.
  - pc + 4 at max word address wraps to 0.
  - Negative br_offset (two's complement) moves backwards.
  - retired wraps from 2^CNT_W-1 to 0.
- Ignored inputs:
  - imem_ack outside FETCH is ignored (spurious ack does not change instr).
  - instr_accept outside HOLD is ignored.
  - branch/uncond_branch/zero/br_offset are ignored outside the accept cycle.
  - X on branch while uncond_branch=1 must not corrupt pc; uncond_branch dominates.
- Throughput: at best one instruction per 2 cycles (FETCH with immediate ack, then HOLD with immediate accept).
- Reset mid-operation: asynchronous return to the reset values in any state. A pending fetch is abandoned and its late ack (arriving in BOOT) is ignored.

Test Plan:
- Reset, then ack every FETCH with 0x8B020020; accept each immediately.
  - instr_valid first rises 2 cycles after reset release.
  - opcode = 11'b10001011000.
  - pc_out sequence 0, 4, 8, 12; retired = 4.
- Hold imem_ack low 5 cycles in FETCH.
  - imem_req stays 1 and imem_addr stays constant.
  - Ack on cycle 6 then leads to instr_valid=1 on the following cycle.
- At pc=0x40 with uncond_branch=1, br_offset=-4 (0xFFFF_FFFF_FFFF_FFFC), accept.
  - Next imem_addr = 0x30.
- CBZ at pc=0x100, branch=1, br_offset=3:
  - zero=1 -> next pc = 0x10C.
  - Repeat with zero=0 -> next pc = 0x104.
- Assert resetl=0 while in FETCH waiting for ack; pulse imem_ack during BOOT after release.
  - instr stays 0, pc = RESET_PC.
  - Fetch restarts at RESET_PC.
- Set pc near the top (RESET_PC = 2^64-4), run one sequential accept.
  - pc wraps to 0.
  - imem_ack pulses while in HOLD leave instr unchanged.
